// File: rtl/lut_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lut_seq_pkg : shared types and helpers for the LUT layer sequencer         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lut_seq_pkg;

    localparam int DEF_NEURONS = 16;
    localparam int DEF_FANIN   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } lut_seq_state_e;

    // Bit position of neuron n's fan-in slice within the packed layer input.
    function automatic int fanin_lsb(input int n, input int fanin);
        return n * fanin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_seq_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lut_seq_table : NEURONS x 2^FANIN single-bit distributed truth-table RAM   |
// | Optional macro LUT_SEQ_READBACK_EN adds an async readback port. Rev 1.0    |
// +----------------------------------------------------------------------------+
module lut_seq_table #(
    parameter int NEURONS = 16,
    parameter int FANIN   = 8,
    parameter int IDX_W   = $clog2(NEURONS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_neuron_i,
    input  logic [FANIN-1:0] wr_addr_i,
    input  logic             wr_data_i,
    input  logic [IDX_W-1:0] ev_neuron_i,
    input  logic [FANIN-1:0] ev_addr_i,
    output logic             ev_data_o
`ifdef LUT_SEQ_READBACK_EN
    ,
    input  logic [IDX_W-1:0] rb_neuron_i,
    input  logic [FANIN-1:0] rb_addr_i,
    output logic             rb_data_o
`endif
);

    // Contents are intentionally never reset so tables survive rst_n.
    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [2**FANIN-1:0] mem_q [NEURONS];

    always_ff @(posedge clk) begin
        if (we_i && (int'(wr_neuron_i) < NEURONS)) begin
            mem_q[wr_neuron_i][wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        ev_data_o = 1'b0;
        if (int'(ev_neuron_i) < NEURONS) begin
            ev_data_o = mem_q[ev_neuron_i][ev_addr_i];
        end
    end

`ifdef LUT_SEQ_READBACK_EN
    always_comb begin
        rb_data_o = 1'b0;
        if (int'(rb_neuron_i) < NEURONS) begin
            rb_data_o = mem_q[rb_neuron_i][rb_addr_i];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/lut_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lut_layer_sequencer : time-multiplexed LogicNets layer, one neuron/cycle   |
// | Optional macro LUT_SEQ_READBACK_EN adds cfg_rdata. Rev 1.0                 |
// +----------------------------------------------------------------------------+
module lut_layer_sequencer
    import lut_seq_pkg::*;
#(
    parameter int NEURONS = DEF_NEURONS,
    parameter int FANIN   = DEF_FANIN,
    parameter int IDX_W   = $clog2(NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_neuron,
    input  logic [FANIN-1:0]         cfg_addr,
    input  logic                     cfg_data,
    output logic                     cfg_err,
`ifdef LUT_SEQ_READBACK_EN
    output logic                     cfg_rdata,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEURONS*FANIN-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEURONS-1:0]       out_data,
    output logic                     busy
);

    lut_seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]         idx_q;
    logic [NEURONS*FANIN-1:0] in_reg_q;
    logic [NEURONS-1:0]       out_vec_q;
    logic                     cfg_err_q;

    logic                     w_last;
    logic                     w_cfg_wr;
    logic                     w_eval_bit;
    logic [FANIN-1:0]         w_eval_addr;

    assign w_last      = (idx_q == IDX_W'(NEURONS - 1));
    assign w_cfg_wr    = cfg_we && (state_q == IDLE);
    assign w_eval_addr = in_reg_q[fanin_lsb(int'(idx_q), FANIN) +: FANIN];

    lut_seq_table #(
        .NEURONS (NEURONS),
        .FANIN   (FANIN),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk         (clk),
        .we_i        (w_cfg_wr),
        .wr_neuron_i (cfg_neuron),
        .wr_addr_i   (cfg_addr),
        .wr_data_i   (cfg_data),
        .ev_neuron_i (idx_q),
        .ev_addr_i   (w_eval_addr),
        .ev_data_o   (w_eval_bit)
`ifdef LUT_SEQ_READBACK_EN
        ,
        .rb_neuron_i (cfg_neuron),
        .rb_addr_i   (cfg_addr),
        .rb_data_o   (cfg_rdata)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = EVAL;
            EVAL:    if (w_last)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Rejected writes are flagged one cycle later, one pulse per dropped strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            in_reg_q  <= '0;
            out_vec_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && (state_q != IDLE);
            if ((state_q == IDLE) && in_valid) begin
                in_reg_q <= in_data;
                idx_q    <= '0;
            end else if (state_q == EVAL) begin
                out_vec_q[idx_q] <= w_eval_bit;
                idx_q            <= w_last ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign out_data = out_vec_q;
    assign cfg_err  = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lut_layer_sequencer : self-checking bench for lut_layer_sequencer       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lut_layer_sequencer;

    localparam int N  = 16;
    localparam int F  = 8;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IW-1:0]    cfg_neuron = '0;
    logic [F-1:0]     cfg_addr = '0;
    logic             cfg_data = 1'b0;
    logic             cfg_err;
`ifdef LUT_SEQ_READBACK_EN
    logic             cfg_rdata;
`endif
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*F-1:0]   in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_data;
    logic             busy;

    lut_layer_sequencer #(.NEURONS(N), .FANIN(F)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err),
`ifdef LUT_SEQ_READBACK_EN
        .cfg_rdata  (cfg_rdata),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int accept_cyc = 0;

    // Reference: one truth table per neuron, written alongside every accepted cfg write.
    bit mdl [N][256];

    typedef struct {
        logic [N*F-1:0] din;
        logic [N-1:0]   dout;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] mdl_eval(input logic [N*F-1:0] v);
        logic [N-1:0] r;
        for (int n = 0; n < N; n++) begin
            r[n] = mdl[n][v[n*F +: F]];
        end
        return r;
    endfunction

    function automatic logic [N*F-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cfg_write(input int n, input int a, input bit d);
        cfg_we     = 1'b1;
        cfg_neuron = IW'(n);
        cfg_addr   = F'(a);
        cfg_data   = d;
        tick();
        cfg_we     = 1'b0;
        mdl[n][a]  = d;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (in_ready !== 1'b1 && g < 64) begin
            tick();
            g++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_in_ready timeout actual=%b required=1", in_ready);
        end
    endtask

    task automatic wait_valid(input string name);
        int g = 0;
        while (out_valid !== 1'b1 && g < 64) begin
            tick();
            g++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s out_valid timeout actual=%b required=1", name, out_valid);
        end
    endtask

    task automatic send(input logic [N*F-1:0] v);
        wait_ready();
        in_valid = 1'b1;
        in_data  = v;
        tick();
        accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // Full transaction with out_ready high: latency and data checked, then back to IDLE.
    task automatic expect_vec(input string name, input logic [N*F-1:0] v, input logic [N-1:0] exp);
        send(v);
        wait_valid(name);
        check({name, "_latency"}, cyc - accept_cyc, N);
        check({name, "_data"}, out_data, exp);
        tick();
    endtask

    logic [N*F-1:0] cur, v;
    logic [N-1:0]   exp_q;
    logic [7:0]     av;
    int             prev_acc, seen;

    initial begin
        #200_000_0;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_state", {in_ready, out_valid, cfg_err, busy, out_data}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});

        // Directed table: only neuron 3 entry A5 is set.
        for (int n = 0; n < N; n++)
            for (int a = 0; a < 256; a++)
                cfg_write(n, a, (n == 3 && a == 8'hA5));
        vecs[0].din = '0; vecs[0].din[3*F +: F] = 8'hA5; vecs[0].dout = 16'h0008;
        vecs[1].din = '0;                                vecs[1].dout = 16'h0000;
        vecs[2].din = '0; vecs[2].din[3*F +: F] = 8'hA4; vecs[2].dout = 16'h0000;
        vecs[3].din = {16{8'hA5}};                       vecs[3].dout = 16'h0008;
        vecs[4].din = '0; vecs[4].din[2*F +: F] = 8'hA5; vecs[4].dout = 16'h0000;
        for (int i = 0; i < 5; i++) expect_vec($sformatf("table_vec%0d", i), vecs[i].din, vecs[i].dout);

        // Parity tables, in_valid held high: back-to-back accepts, data changes during EVAL.
        for (int n = 0; n < N; n++)
            for (int a = 0; a < 256; a++) begin
                av = 8'(a);
                cfg_write(n, a, ^av);
            end
        out_ready = 1'b1;
        prev_acc  = -1;
        cur       = rand_vec();
        in_data   = cur;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ready();
            tick();
            accept_cyc = cyc;
            exp_q = mdl_eval(cur);
            if (prev_acc >= 0) check("accept_spacing", accept_cyc - prev_acc, N + 2);
            prev_acc = accept_cyc;
            cur     = rand_vec();
            in_data = cur;
            if (k == 7) in_valid = 1'b0;
            wait_valid("parity");
            check("parity_latency", cyc - accept_cyc, N);
            check("parity_data", out_data, exp_q);
        end
        tick();

        // Backpressure in DONE; a cfg write there is rejected.
        out_ready = 1'b0;
        v = rand_vec();
        v[0 +: 2*F] = '0;
        exp_q = mdl_eval(v);
        send(v);
        wait_valid("hold");
        in_valid = 1'b1;
        in_data  = ~v;
        for (int i = 0; i < 10; i++) begin
            check("hold_stable", {out_valid, in_ready, out_data}, {1'b1, 1'b0, exp_q});
            if (i == 2) begin
                cfg_we = 1'b1; cfg_neuron = 4'd1; cfg_addr = 8'h00; cfg_data = ~mdl[1][0];
            end
            if (i == 3) begin
                cfg_we = 1'b0;
                check("cfg_err_done", cfg_err, 1'b1);
            end
            if (i == 4) check("cfg_err_done_clear", cfg_err, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hold_release", {out_valid, in_ready}, 2'b01);
        tick();
        check("idle_out_ready", {out_valid, in_ready, busy}, 3'b010);

        // Write attempted during EVAL must be dropped.
        v = rand_vec();
        v[0 +: F] = '0;
        send(v);
        tick();
        tick();
        cfg_we = 1'b1; cfg_neuron = 4'd0; cfg_addr = 8'h00; cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("cfg_err_eval", cfg_err, 1'b1);
        tick();
        check("cfg_err_eval_clear", cfg_err, 1'b0);
        wait_valid("eval_write");
        check("eval_write_data", out_data, mdl_eval(v));
        tick();
        v = rand_vec();
        v[0 +: 2*F] = '0;
        expect_vec("reeval_after_reject", v, mdl_eval(v));

        // Same-cycle cfg write and accept: evaluation sees the new entry.
        cfg_write(5, 1, 1'b0);
        v = rand_vec();
        v[5*F +: F] = 8'h01;
        cfg_we = 1'b1; cfg_neuron = 4'd5; cfg_addr = 8'h01; cfg_data = 1'b1;
        in_valid = 1'b1; in_data = v;
        tick();
        accept_cyc = cyc;
        cfg_we = 1'b0; in_valid = 1'b0;
        mdl[5][1] = 1'b1;
        check("same_cycle_no_err", cfg_err, 1'b0);
        wait_valid("same_cycle");
        check("same_cycle_data", out_data, mdl_eval(v));
        check("same_cycle_bit5", out_data[5], 1'b1);
        tick();

        // Random truth tables against the model.
        for (int n = 0; n < N; n++)
            for (int a = 0; a < 256; a++)
                cfg_write(n, a, bit'($urandom_range(1, 0)));
        for (int i = 0; i < 6; i++) begin
            v = rand_vec();
            expect_vec("random_tbl", v, mdl_eval(v));
        end

        // Reset at EVAL idx=7 aborts the vector; tables survive.
        v = rand_vec();
        send(v);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("reset_async", {busy, in_ready, out_valid, out_data}, {1'b0, 1'b1, 1'b0, 16'h0000});
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check("no_valid_after_reset", seen, 0);
        check("ready_after_reset", {in_ready, busy}, 2'b10);
`ifdef LUT_SEQ_READBACK_EN
        for (int i = 0; i < 8; i++) begin
            int rn, ra;
            rn = $urandom_range(N - 1, 0);
            ra = $urandom_range(255, 0);
            cfg_neuron = IW'(rn);
            cfg_addr   = F'(ra);
            #1;
            check("readback", cfg_rdata, mdl[rn][ra]);
        end
`endif
        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            expect_vec("post_reset", v, mdl_eval(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
